// File: rtl/post_norm_md_pipe_pkg.sv
// Shared widths and the S1->S2 stage record for the post-normalisation pipe.
// The stage record is sized for the package default exponent/fraction widths.
package FPU_192_Package;

  localparam int PN_EXP_W  = 8;
  localparam int PN_FRAC_W = 23;
  localparam int PN_MAN_W  = PN_FRAC_W + 4;
  localparam int PN_EXP_IW = PN_EXP_W + 2;

  typedef struct packed {
    logic                        sign;
    logic signed [PN_EXP_IW-1:0] exp_s;
    logic [PN_FRAC_W-1:0]        frac;
    logic                        guard;
    logic                        sticky;
    logic                        zero;
  } pn_stage_t;

endpackage

// File: rtl/post_norm_md_pipe_lzc.sv
// Leading-zero counter; count equals W when the input is all zero.
module pn_lzc #(
  parameter int W = 24
) (
  input  logic [W-1:0]             vec_i,
  output logic [$clog2(W+1)-1:0]   cnt_o,
  output logic                     zero_o
);

  localparam int CNT_W = $clog2(W + 1);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) cnt_o = CNT_W'(W - 1 - i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/post_norm_md_pipe.sv
// Two-stage post-normalisation for multiply/divide results: S1 normalises, S2 rounds and packs.
// Define PN_ROUND_EN for round-to-nearest-even in S2; otherwise S2 truncates.
module post_norm_md_pipe
  import FPU_192_Package::*;
#(
  parameter int EXP_W  = PN_EXP_W,
  parameter int FRAC_W = PN_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    div_mul,
  input  logic                    sign,
  input  logic [EXP_W-1:0]        exp,
  input  logic [FRAC_W+3:0]       mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   nor_result,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int MAN_W = FRAC_W + 4;
  localparam int EI_W  = EXP_W + 2;
  localparam int LZ_W  = FRAC_W + 1;
  localparam int CNT_W = $clog2(FRAC_W + 2);
  localparam logic signed [EI_W-1:0] EXP_MAX  = EI_W'((1 << EXP_W) - 1);
  localparam logic signed [EI_W-1:0] EXP_ZERO = '0;

  logic                  s1_valid_q, s2_valid_q;
  logic                  s1_advance, s2_free;
  pn_stage_t             s1_d, s1_q;
  logic [EXP_W+FRAC_W:0] res_d, nor_result_q;
  logic                  ovf_d, unf_d, ovf_q, unf_q;

  logic [CNT_W-1:0]      lz_cnt;
  logic                  lz_zero;
  logic [FRAC_W+2:0]     div_vec, div_shift;

  assign s2_free    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_free;
  assign in_ready   = !s1_valid_q || s1_advance;

  pn_lzc #(.W(LZ_W)) u_lzc (
    .vec_i  (mant[MAN_W-2:2]),
    .cnt_o  (lz_cnt),
    .zero_o (lz_zero)
  );

  // S1: mul results need at most a one-bit right shift, div results a left shift.
  always_comb begin
    s1_d      = '0;
    div_vec   = mant[MAN_W-2:0];
    div_shift = div_vec << lz_cnt;
    s1_d.sign = sign;
    if (div_mul) begin
      s1_d.exp_s  = EI_W'(exp) - EI_W'(lz_cnt);
      s1_d.frac   = div_shift[FRAC_W+1:2];
      s1_d.guard  = div_shift[1];
      s1_d.sticky = div_shift[0];
      s1_d.zero   = lz_zero;
    end else if (mant[MAN_W-1]) begin
      s1_d.exp_s  = EI_W'(exp) + EI_W'(1);
      s1_d.frac   = mant[FRAC_W+2:3];
      s1_d.guard  = mant[2];
      s1_d.sticky = mant[1] | mant[0];
    end else begin
      s1_d.exp_s  = EI_W'(exp);
      s1_d.frac   = mant[FRAC_W+1:2];
      s1_d.guard  = mant[1];
      s1_d.sticky = mant[0];
    end
  end

  logic                   round_up;
  logic [FRAC_W:0]        frac_rnd;
  logic signed [EI_W-1:0] exp_fin;
  logic                   unused_gs;

  assign unused_gs = s1_q.guard ^ s1_q.sticky;

  // S2: round, absorb fraction carry, then saturate or flush.
  always_comb begin
`ifdef PN_ROUND_EN
    round_up = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
`else
    round_up = 1'b0;
`endif
    frac_rnd = {1'b0, s1_q.frac} + {{FRAC_W{1'b0}}, round_up};
    exp_fin  = s1_q.exp_s + EI_W'(frac_rnd[FRAC_W]);
    res_d    = {s1_q.sign, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (s1_q.zero) begin
      res_d = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (exp_fin >= EXP_MAX) begin
      res_d = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      res_d = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_q         <= '0;
      nor_result_q <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          nor_result_q <= res_d;
          ovf_q        <= ovf_d;
          unf_q        <= unf_d;
        end
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign nor_result = nor_result_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: doc/post_norm_md_pipe.md
POST_NORM_MD_PIPE -- requirements
Module: post_norm_md_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width; MAN_W = FRAC_W+4 is derived.
REQ-003 SHALL have port clk  input  1  clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port div_mul  input  1  0 = multiply result, 1 = divide result.
REQ-008 SHALL have port sign  input  1  result sign.
REQ-009 SHALL have port exp  input  EXP_W  pre-normalization biased exponent.
REQ-010 SHALL have port mant  input  MAN_W  mantissa: [MAN_W-1] mul carry bit, [MAN_W-2] hidden bit, [FRAC_W+1:2] fraction, [1] guard, [0] sticky.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port nor_result  output  1+EXP_W+FRAC_W  packed {sign, exponent, fraction}.
REQ-014 SHALL have ports overflow, underflow  output  1 each  flags aligned with nor_result.

Function
REQ-015 SHALL transfer a beat on in_valid&&in_ready and a result on out_valid&&out_ready.
REQ-016 SHALL be a 2-stage pipeline, S1 normalize, S2 round/pack; latency 2 cycles from accept to out_valid; throughput 1 beat/cycle with out_ready high.
REQ-017 S2 SHALL hold its contents and outputs stable while out_valid&&!out_ready; S1 SHALL advance only when S2 is empty or draining; in_ready = !s1_valid || s1_advance.
REQ-018 Mul mode: carry bit set -> mantissa right-shift 1, shifted-out bit ORed into sticky, exponent +1; carry clear -> no shift.
REQ-019 Div mode: leading-zero count over mant[MAN_W-2:2] (carry bit ignored), left-shift by count, guard/sticky shift in behind, exponent minus count.
REQ-020 Exponent arithmetic SHALL use EXP_W+2-bit signed internal width; no wrap-around.
REQ-021 Rounding carry-out of fraction SHALL set fraction to zero and exponent +1 in S2.
REQ-022 Final exponent >= 2^EXP_W-1 SHALL give signed infinity (exp all ones, fraction 0), overflow=1.
REQ-023 Final exponent <= 0 SHALL give signed zero (flush, no denormals), underflow=1.
REQ-024 All-zero mant[MAN_W-2:2] in div mode SHALL give signed zero, both flags 0.
REQ-025 overflow and underflow SHALL never be set together.

Reset
REQ-026 rst_n low SHALL clear s1_valid, s2_valid, out_valid, nor_result, overflow and underflow to 0 on the next edge, discarding in-flight beats; in_ready = 1 from the first cycle after reset.
REQ-027 Reset mid-stall SHALL drop held data; no result is presented after reset release until a new beat is accepted.

Configuration
REQ-028 With PN_ROUND_EN defined, S2 SHALL round to nearest even using guard, sticky and fraction LSB.
REQ-029 Without PN_ROUND_EN, S2 SHALL truncate (guard/sticky ignored); latency and handshake unchanged.

Structure
REQ-030 EXP_W/FRAC_W defaults, the MAN_W derivation and a packed S1-to-S2 stage struct SHALL live in FPU_192_Package.
REQ-031 Leading-zero counting SHALL be a separate parametrised sub-module pn_lzc, width FRAC_W+1, count output width $clog2(FRAC_W+2).

Verification
REQ-032 Mul, exp=0x7F, hidden=1, fraction/guard/sticky 0 -> 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
REQ-033 Mul, exp=0x80, carry=1, hidden=1, fraction 0 -> 0x40C00000 (exponent 0x81).
REQ-034 Div, exp=0x80, hidden=0, next bit 1 -> 0x3F800000; div, exp=0x01, two leading zeros -> 0x00000000, underflow=1.
REQ-035 Mul, exp=0xFE, carry=1 -> 0x7F800000, overflow=1; sign=1 -> 0xFF800000.
REQ-036 Mul, exp=0x7F, fraction all ones, guard=1, sticky=1 -> 0x40000000 with PN_ROUND_EN, 0x3FFFFFFF without.
REQ-037 Stream 4 beats with out_ready low 3 cycles -> nor_result held stable, in_ready low once both stages full, all 4 results in order with none lost or duplicated.
